tt_bist_harness: RTL

//  Synthesizable built-in self-test wrapper for a tt_um_* user design; sits between the pad ring and the user top.
//  In IDLE/DONE, the pad inputs pass through to the design unchanged.
//  On start: holds the design in reset, drives it with LFSR stimulus for NUM_CYCLES cycles,
//  and compacts its outputs into a MISR signature.

---
 rtl/tt_bist_harness.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/tt_bist_harness.sv
// tt_bist_harness: built-in self-test wrapper placed between the pad ring and a
// tt_um_* user design. Pads pass through when idle; on start the design is reset,
// driven with LFSR stimulus and its responses are compacted into a MISR signature
// that is compared against a golden value.
module tt_bist_harness #(
    parameter int               IN_W       = 8,
    parameter int               OUT_W      = 8,
    parameter int               SIG_W      = 16,
    parameter int               NUM_CYCLES = 256,
    parameter int               RST_CYCLES = 4,
    parameter int               LATENCY    = 1,
    parameter logic [IN_W-1:0]  STIM_POLY  = 8'h1D,
    parameter logic [IN_W-1:0]  STIM_SEED  = 8'h01,
    parameter logic [SIG_W-1:0] SIG_POLY   = 16'h1021
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [IN_W-1:0]  byp_in,
    input  logic [SIG_W-1:0] golden,
    input  logic [OUT_W-1:0] resp_in,
    output logic [IN_W-1:0]  stim_out,
    output logic             dut_rst_n,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RESET = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // One counter covers RESET, and RUN+DRAIN as a single continuous span, so the
    // capture window can be expressed as "span index >= LATENCY".
    localparam int CNT_W = $clog2(NUM_CYCLES + LATENCY + RST_CYCLES + 1);

    localparam logic [IN_W-1:0]  SEED_EFF    = (STIM_SEED == {IN_W{1'b0}}) ?
                                               {{(IN_W-1){1'b0}}, 1'b1} : STIM_SEED;
    localparam logic [CNT_W-1:0] CNT_ONE     = 1;
    localparam logic [CNT_W:0]   CNT_EXT_ONE = 1;
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(NUM_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(NUM_CYCLES + LATENCY - 1);
    localparam logic [CNT_W:0]   LAT_EXT     = (CNT_W+1)'(LATENCY);

    // Galois LFSR advance for the stimulus generator.
    function automatic logic [IN_W-1:0] lfsr_step(input logic [IN_W-1:0] v);
        return {v[IN_W-2:0], 1'b0} ^ (v[IN_W-1] ? STIM_POLY : {IN_W{1'b0}});
    endfunction

    // MISR compaction step: shift with feedback, then fold in the response.
    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                   input logic [OUT_W-1:0] r);
        return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? SIG_POLY : {SIG_W{1'b0}}) ^ SIG_W'(r);
    endfunction

    logic [2:0]       state_r, state_next_s;
    logic [CNT_W-1:0] cnt_r, cnt_next_s;
    logic [IN_W-1:0]  lfsr_r, lfsr_next_s;
    logic [SIG_W-1:0] sig_r, sig_next_s;
    logic             pass_r, pass_next_s;
    logic             dut_rst_n_r, busy_r, done_r;
    logic             abort_s, capture_s, enter_reset_s, enter_done_s;

    // Abort only has an effect while a test is in progress.
    always_comb begin
        abort_s = abort && ((state_r == ST_RESET) || (state_r == ST_RUN) || (state_r == ST_DRAIN));
    end

    // Next-state and phase counter; abort overrides every other transition.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        if (abort_s) begin
            state_next_s = ST_IDLE;
            cnt_next_s   = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    cnt_next_s   = {CNT_W{1'b0}};
                    state_next_s = start ? ST_RESET : state_r;
                end
                ST_RESET: begin
                    if (cnt_r == RST_LAST) begin
                        state_next_s = ST_RUN;
                        cnt_next_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_next_s   = cnt_r + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    if ((cnt_r == RUN_LAST) && (LATENCY == 0)) begin
                        state_next_s = ST_DONE;
                        cnt_next_s   = {CNT_W{1'b0}};
                    end else if (cnt_r == RUN_LAST) begin
                        state_next_s = ST_DRAIN;
                        cnt_next_s   = cnt_r + CNT_ONE;
                    end else begin
                        cnt_next_s   = cnt_r + CNT_ONE;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_r == DRAIN_LAST) begin
                        state_next_s = ST_DONE;
                        cnt_next_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_next_s   = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Capture window: the last NUM_CYCLES cycles of RUN+DRAIN (span index >= LATENCY).
    always_comb begin
        if ((state_r == ST_RUN) || (state_r == ST_DRAIN)) begin
            capture_s = (({1'b0, cnt_r} + CNT_EXT_ONE) > LAT_EXT);
        end else begin
            capture_s = 1'b0;
        end
    end

    // Datapath next values: LFSR, MISR and the pass verdict.
    always_comb begin
        enter_reset_s = (state_next_s == ST_RESET) && (state_r != ST_RESET);
        enter_done_s  = (state_next_s == ST_DONE) && (state_r != ST_DONE);

        if (enter_reset_s) begin
            lfsr_next_s = SEED_EFF;
        end else if (state_r == ST_RUN) begin
            lfsr_next_s = lfsr_step(lfsr_r);
        end else begin
            lfsr_next_s = lfsr_r;
        end

        if (abort_s || enter_reset_s) begin
            sig_next_s = {SIG_W{1'b0}};
        end else if (capture_s) begin
            sig_next_s = misr_step(sig_r, resp_in);
        end else begin
            sig_next_s = sig_r;
        end

        if (abort_s || enter_reset_s) begin
            pass_next_s = 1'b0;
        end else if (enter_done_s) begin
            pass_next_s = (sig_next_s == golden);
        end else begin
            pass_next_s = pass_r;
        end
    end

    // State, datapath and status registers; status flags follow the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            lfsr_r      <= SEED_EFF;
            sig_r       <= {SIG_W{1'b0}};
            pass_r      <= 1'b0;
            dut_rst_n_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            lfsr_r      <= lfsr_next_s;
            sig_r       <= sig_next_s;
            pass_r      <= pass_next_s;
            dut_rst_n_r <= (state_next_s != ST_RESET);
            busy_r      <= (state_next_s == ST_RESET) || (state_next_s == ST_RUN) ||
                           (state_next_s == ST_DRAIN);
            done_r      <= (state_next_s == ST_DONE);
        end
    end

    // Stimulus mux: pads pass straight through whenever no test is running.
    always_comb begin
        case (state_r)
            ST_RUN:             stim_out = lfsr_r;
            ST_RESET, ST_DRAIN: stim_out = {IN_W{1'b0}};
            default:            stim_out = byp_in;
        endcase
    end

    assign dut_rst_n = dut_rst_n_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign signature = sig_r;

endmodule
